text_buffer_ctrl: RTL and testbench

- Owns the write/maintenance port (port A) of the 160x45 text-mode frame-buffer BRAM (16-bit words: code point in [15:8], attribute in [7:0]); the display scan reads port B independently.
- Arbitrates single-word CPU writes against two bulk commands: clear-screen (fill every cell) and scroll-up (move rows 1..ROWS-1 up one row, fill last row).
- Sits between the CPU/MMIO bus and the BRAM port-A pins.

---
 rtl/text_buffer_ctrl_if.sv | 36 +++
 rtl/text_buffer_ctrl.sv | 173 +++++++++++++++++
 tb/tb_text_buffer_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_buffer_ctrl_if.sv
// Bus bundle between the CPU/MMIO side, the text buffer controller and BRAM port A.
// The slave modport is the controller's view; the master modport is the bus/BRAM side.
interface text_buffer_ctrl_if #(
   parameter int unsigned ADDR_WIDTH = 13,
   parameter int unsigned DATA_WIDTH = 16
);
   logic                  cpu_valid_in;
   logic                  cpu_ready_out;
   logic [ADDR_WIDTH-1:0] cpu_addr_in;
   logic [DATA_WIDTH-1:0] cpu_data_in;
   logic                  cmd_valid_in;
   logic                  cmd_ready_out;
   logic [1:0]            cmd_in;
   logic [DATA_WIDTH-1:0] fill_in;
   logic                  busy_out;
   logic                  done_out;
   logic                  bram_en_out;
   logic                  bram_we_out;
   logic [ADDR_WIDTH-1:0] bram_addr_out;
   logic [DATA_WIDTH-1:0] bram_din_out;
   logic [DATA_WIDTH-1:0] bram_dout_in;

   modport slave (
      input  cpu_valid_in, cpu_addr_in, cpu_data_in, cmd_valid_in, cmd_in, fill_in,
             bram_dout_in,
      output cpu_ready_out, cmd_ready_out, busy_out, done_out, bram_en_out, bram_we_out,
             bram_addr_out, bram_din_out
   );

   modport master (
      output cpu_valid_in, cpu_addr_in, cpu_data_in, cmd_valid_in, cmd_in, fill_in,
             bram_dout_in,
      input  cpu_ready_out, cmd_ready_out, busy_out, done_out, bram_en_out, bram_we_out,
             bram_addr_out, bram_din_out
   );
endinterface

// File: rtl/text_buffer_ctrl.sv
// Text-mode frame-buffer port-A controller: single CPU writes plus bulk clear-screen and
// scroll-up commands. All BRAM pins are registered, so a decision shows up one cycle later.
module text_buffer_ctrl #(
   parameter int unsigned COLS         = 160,
   parameter int unsigned ROWS         = 45,
   parameter int unsigned ADDR_WIDTH   = 13,
   parameter int unsigned DATA_WIDTH   = 16,
   parameter int unsigned READ_LATENCY = 2
) (
   input logic             clk_in,
   input logic             rst_in,
   text_buffer_ctrl_if.slave bus
);
   localparam int unsigned CELLS  = COLS * ROWS;
   localparam int unsigned WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(CELLS - 1);
   localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(COLS);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
   localparam logic [WAIT_W-1:0]     WAIT_LAST  = WAIT_W'(READ_LATENCY - 1);
   localparam logic [WAIT_W-1:0]     WAIT_ONE   = WAIT_W'(1);

   typedef enum logic [2:0] {
      StIdle, StClear, StScrRd, StScrWait, StScrWr, StScrFill
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] src_q, src_d;
   logic [ADDR_WIDTH-1:0] dst_q, dst_d;
   logic [WAIT_W-1:0]     wait_q, wait_d;
   logic [DATA_WIDTH-1:0] fill_q, fill_d;
   logic [DATA_WIDTH-1:0] word_q, word_d;
   logic                  en_q, en_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] din_q, din_d;
   logic                  done_q, done_d;
   logic                  idle;

   // Handshake and status outputs; ready stays low while reset is held.
   assign idle              = (state_q == StIdle);
   assign bus.busy_out      = !idle;
   assign bus.cpu_ready_out = idle && !rst_in;
   assign bus.cmd_ready_out = idle && !rst_in && !bus.cpu_valid_in;
   assign bus.done_out      = done_q;
   assign bus.bram_en_out   = en_q;
   assign bus.bram_we_out   = we_q;
   assign bus.bram_addr_out = addr_q;
   assign bus.bram_din_out  = din_q;

   // State register, counters and registered BRAM port-A pins.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= StIdle;
         src_q   <= '0;
         dst_q   <= '0;
         wait_q  <= '0;
         fill_q  <= '0;
         word_q  <= '0;
         en_q    <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         wait_q  <= wait_d;
         fill_q  <= fill_d;
         word_q  <= word_d;
         en_q    <= en_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic: arbitration in idle, then one BRAM access per cycle for bulk commands.
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      wait_d  = wait_q;
      fill_d  = fill_q;
      word_d  = word_q;
      en_d    = 1'b0;
      we_d    = 1'b0;
      addr_d  = addr_q;
      din_d   = din_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.cpu_valid_in) begin
               // Out-of-range cells are accepted but never reach the BRAM.
               if (bus.cpu_addr_in <= LAST_ADDR) begin
                  en_d   = 1'b1;
                  we_d   = 1'b1;
                  addr_d = bus.cpu_addr_in;
                  din_d  = bus.cpu_data_in;
               end
            end else if (bus.cmd_valid_in) begin
               fill_d = bus.fill_in;
               unique case (bus.cmd_in)
                  2'b01: begin
                     dst_d   = '0;
                     state_d = StClear;
                  end
                  2'b10: begin
                     src_d   = ROW_STRIDE;
                     dst_d   = '0;
                     state_d = StScrRd;
                  end
                  default: done_d = 1'b1;
               endcase
            end
         end
         StClear: begin
            en_d   = 1'b1;
            we_d   = 1'b1;
            addr_d = dst_q;
            din_d  = fill_q;
            if (dst_q == LAST_ADDR) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end else begin
               dst_d = dst_q + ADDR_ONE;
            end
         end
         StScrRd: begin
            en_d    = 1'b1;
            addr_d  = src_q;
            wait_d  = '0;
            state_d = StScrWait;
         end
         StScrWait: begin
            if (wait_q == WAIT_LAST) begin
               word_d  = bus.bram_dout_in;
               state_d = StScrWr;
            end else begin
               wait_d = wait_q + WAIT_ONE;
            end
         end
         StScrWr: begin
            en_d   = 1'b1;
            we_d   = 1'b1;
            addr_d = dst_q;
            din_d  = word_q;
            // dst ends up on the first cell of the last row, ready for the fill pass.
            dst_d  = dst_q + ADDR_ONE;
            if (src_q == LAST_ADDR) begin
               state_d = StScrFill;
            end else begin
               src_d   = src_q + ADDR_ONE;
               state_d = StScrRd;
            end
         end
         StScrFill: begin
            en_d   = 1'b1;
            we_d   = 1'b1;
            addr_d = dst_q;
            din_d  = fill_q;
            if (dst_q == LAST_ADDR) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end else begin
               dst_d = dst_q + ADDR_ONE;
            end
         end
         default: state_d = StIdle;
      endcase
   end
endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Self-checking bench for text_buffer_ctrl: table-driven CPU writes, randomized CPU/no-op
// traffic against a reference memory image, and hand-written bulk-command sequences.
module tb_text_buffer_ctrl;
   localparam int unsigned COLS  = 160;
   localparam int unsigned ROWS  = 45;
   localparam int unsigned AW    = 13;
   localparam int unsigned DW    = 16;
   localparam int unsigned RL    = 2;
   localparam int unsigned CELLS = COLS * ROWS;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic preload = 1'b0;
   int   tests_run = 0;
   int   tests_failed = 0;

   text_buffer_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   text_buffer_ctrl #(
      .COLS(COLS), .ROWS(ROWS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)
   ) dut (
      .clk_in(clk),
      .rst_in(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // BRAM model: data for a read is presented READ_LATENCY cycles after the controller
   // issues it, i.e. one cycle after the registered enable is on the pins.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] ref_mem [0:CELLS-1];
   logic [DW-1:0] rd_q;
   assign bus.bram_dout_in = rd_q;

   // Port-A array and read register; preload fills word[i]=i.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < CELLS; i++) mem[AW'(i)] <= DW'(i);
      end else if (bus.bram_en_out && bus.bram_we_out) begin
         mem[bus.bram_addr_out] <= bus.bram_din_out;
      end
      if (bus.bram_en_out && !bus.bram_we_out) rd_q <= mem[bus.bram_addr_out];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int mem_mismatches();
      int n = 0;
      for (int i = 0; i < CELLS; i++) if (mem[AW'(i)] !== ref_mem[AW'(i)]) n++;
      return n;
   endfunction

   task automatic do_preload();
      @(negedge clk);
      preload = 1'b1;
      @(negedge clk);
      preload = 1'b0;
      for (int i = 0; i < CELLS; i++) ref_mem[AW'(i)] = DW'(i);
   endtask

   // Issues a bulk command and watches the pins until done_out (bounded).
   task automatic run_bulk(input logic [1:0] cmd, input logic [DW-1:0] fill, input int budget,
                           output int writes, output int addr_err, output int din_err,
                           output int gaps, output int busy_cycles, output int ready_err,
                           output bit done_seen, output bit done_with_last);
      writes = 0; addr_err = 0; din_err = 0; gaps = 0; busy_cycles = 0; ready_err = 0;
      done_seen = 1'b0; done_with_last = 1'b0;
      @(negedge clk);
      bus.cmd_valid_in = 1'b1;
      bus.cmd_in       = cmd;
      bus.fill_in      = fill;
      #1 check("bulk_cmd_ready", 32'(bus.cmd_ready_out), 1);
      @(negedge clk);
      bus.cmd_valid_in = 1'b0;
      for (int c = 0; c < budget && !done_seen; c++) begin
         if (bus.bram_en_out && bus.bram_we_out) begin
            if (bus.bram_addr_out !== AW'(writes)) addr_err++;
            if (bus.bram_din_out !== fill) din_err++;
            writes++;
         end else if (writes > 0 && !bus.done_out) begin
            gaps++;
         end
         if (bus.done_out) begin
            done_seen = 1'b1;
            done_with_last = bus.bram_en_out && bus.bram_we_out &&
                             (bus.bram_addr_out == AW'(CELLS - 1));
            if (!bus.cpu_ready_out || bus.busy_out) ready_err++;
         end else begin
            if (bus.busy_out) busy_cycles++;
            if (bus.cpu_ready_out || bus.cmd_ready_out) ready_err++;
            @(negedge clk);
         end
      end
   endtask

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          exp_we;
   } cpu_vec_t;

   initial begin
      cpu_vec_t vecs[6];
      int writes, addr_err, din_err, gaps, busy_cycles, ready_err, cnt;
      bit done_seen, done_with_last;
      logic          exp_en, exp_done;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_din;

      vecs[0] = '{addr: 13'h00A5, data: 16'h410F, exp_we: 1'b1};
      vecs[1] = '{addr: 13'd7200, data: 16'h5555, exp_we: 1'b0};
      vecs[2] = '{addr: 13'd0,    data: 16'h1234, exp_we: 1'b1};
      vecs[3] = '{addr: 13'd7199, data: 16'hFFFF, exp_we: 1'b1};
      vecs[4] = '{addr: 13'd8191, data: 16'hDEAD, exp_we: 1'b0};
      vecs[5] = '{addr: 13'h1000, data: 16'hABCD, exp_we: 1'b1};

      bus.cpu_valid_in = 1'b0;
      bus.cpu_addr_in  = '0;
      bus.cpu_data_in  = '0;
      bus.cmd_valid_in = 1'b0;
      bus.cmd_in       = 2'b00;
      bus.fill_in      = '0;

      // Reset held: everything low, including the ready outputs.
      preload = 1'b1;
      @(negedge clk);
      preload = 1'b0;
      for (int i = 0; i < CELLS; i++) ref_mem[AW'(i)] = DW'(i);
      @(negedge clk);
      check("rst_en", 32'(bus.bram_en_out), 0);
      check("rst_busy", 32'(bus.busy_out), 0);
      check("rst_cpu_ready", 32'(bus.cpu_ready_out), 0);
      rst = 1'b0;
      #1;
      check("rst_rel_cpu_ready", 32'(bus.cpu_ready_out), 1);
      check("rst_rel_cmd_ready", 32'(bus.cmd_ready_out), 1);
      check("rst_rel_done", 32'(bus.done_out), 0);

      // Table-driven single CPU writes.
      foreach (vecs[k]) begin
         @(negedge clk);
         bus.cpu_valid_in = 1'b1;
         bus.cpu_addr_in  = vecs[k].addr;
         bus.cpu_data_in  = vecs[k].data;
         #1 check("tbl_cpu_ready", 32'(bus.cpu_ready_out), 1);
         @(negedge clk);
         bus.cpu_valid_in = 1'b0;
         check("tbl_en", 32'(bus.bram_en_out), 32'(vecs[k].exp_we));
         check("tbl_we", 32'(bus.bram_we_out), 32'(vecs[k].exp_we));
         if (vecs[k].exp_we) begin
            check("tbl_addr", 32'(bus.bram_addr_out), 32'(vecs[k].addr));
            check("tbl_din", 32'(bus.bram_din_out), 32'(vecs[k].data));
            ref_mem[vecs[k].addr] = vecs[k].data;
         end
      end

      // Random CPU writes mixed with no-op commands.
      exp_en = 1'b0; exp_done = 1'b0; exp_addr = '0; exp_din = '0;
      for (int i = 0; i <= 300; i++) begin
         @(negedge clk);
         if (i > 0) begin
            check("rnd_en", 32'(bus.bram_en_out), 32'(exp_en));
            check("rnd_we", 32'(bus.bram_we_out), 32'(exp_en));
            check("rnd_done", 32'(bus.done_out), 32'(exp_done));
            if (exp_en) begin
               check("rnd_addr", 32'(bus.bram_addr_out), 32'(exp_addr));
               check("rnd_din", 32'(bus.bram_din_out), 32'(exp_din));
            end
         end
         bus.cpu_valid_in = ($urandom % 3) != 0 && i < 300;
         bus.cpu_addr_in  = (($urandom % 4) == 0) ? AW'($urandom_range(CELLS, 8191))
                                                 : AW'($urandom_range(0, CELLS - 1));
         bus.cpu_data_in  = DW'($urandom);
         bus.cmd_valid_in = ($urandom % 4) == 0 && i < 300;
         bus.cmd_in       = (($urandom % 2) == 0) ? 2'b00 : 2'b11;
         exp_en   = bus.cpu_valid_in && (bus.cpu_addr_in < AW'(CELLS));
         exp_addr = bus.cpu_addr_in;
         exp_din  = bus.cpu_data_in;
         exp_done = !bus.cpu_valid_in && bus.cmd_valid_in;
         if (exp_en) ref_mem[exp_addr] = exp_din;
      end
      bus.cpu_valid_in = 1'b0;
      bus.cmd_valid_in = 1'b0;
      @(negedge clk);
      check("rnd_mem", 32'(mem_mismatches()), 0);

      // Clear screen.
      run_bulk(2'b01, 16'h2007, CELLS + 50, writes, addr_err, din_err, gaps, busy_cycles,
               ready_err, done_seen, done_with_last);
      check("clr_done_seen", 32'(done_seen), 1);
      check("clr_writes", 32'(writes), CELLS);
      check("clr_addr_seq", 32'(addr_err), 0);
      check("clr_din", 32'(din_err), 0);
      check("clr_gaps", 32'(gaps), 0);
      check("clr_busy_cycles", 32'(busy_cycles), CELLS);
      check("clr_ready", 32'(ready_err), 0);
      check("clr_done_with_last", 32'(done_with_last), 1);
      @(negedge clk);
      check("clr_done_pulse", 32'(bus.done_out), 0);
      check("clr_idle_en", 32'(bus.bram_en_out), 0);
      for (int i = 0; i < CELLS; i++) ref_mem[AW'(i)] = 16'h2007;
      check("clr_mem", 32'(mem_mismatches()), 0);

      // Scroll up on word[i]=i.
      do_preload();
      run_bulk(2'b10, 16'h0000, 40000, writes, addr_err, din_err, gaps, busy_cycles,
               ready_err, done_seen, done_with_last);
      check("scr_done_seen", 32'(done_seen), 1);
      check("scr_writes", 32'(writes), CELLS);
      check("scr_addr_seq", 32'(addr_err), 0);
      check("scr_busy_cycles", 32'(busy_cycles), (CELLS - COLS) * (RL + 2) + COLS);
      check("scr_ready", 32'(ready_err), 0);
      check("scr_done_with_last", 32'(done_with_last), 1);
      @(negedge clk);
      check("scr_done_pulse", 32'(bus.done_out), 0);
      for (int i = 0; i < CELLS; i++)
         ref_mem[AW'(i)] = (i < CELLS - COLS) ? ref_mem[AW'(i + COLS)] : 16'h0000;
      check("scr_mem", 32'(mem_mismatches()), 0);
      check("scr_word0", 32'(mem[0]), 160);
      check("scr_word7039", 32'(mem[7039]), 7199);
      check("scr_word7040", 32'(mem[7040]), 0);

      // Contention: CPU wins, clear follows, CPU stalls until done.
      @(negedge clk);
      bus.cpu_valid_in = 1'b1;
      bus.cpu_addr_in  = 13'd5;
      bus.cpu_data_in  = 16'hBEEF;
      bus.cmd_valid_in = 1'b1;
      bus.cmd_in       = 2'b01;
      bus.fill_in      = 16'h0720;
      #1;
      check("cont_cpu_ready", 32'(bus.cpu_ready_out), 1);
      check("cont_cmd_blocked", 32'(bus.cmd_ready_out), 0);
      @(negedge clk);
      check("cont_cpu_we", 32'(bus.bram_we_out), 1);
      check("cont_cpu_addr", 32'(bus.bram_addr_out), 5);
      check("cont_cpu_din", 32'(bus.bram_din_out), 32'h0000BEEF);
      bus.cpu_valid_in = 1'b0;
      #1 check("cont_cmd_ready", 32'(bus.cmd_ready_out), 1);
      @(negedge clk);
      bus.cmd_valid_in = 1'b0;
      check("cont_busy", 32'(bus.busy_out), 1);
      bus.cpu_valid_in = 1'b1;
      bus.cpu_addr_in  = 13'd10;
      bus.cpu_data_in  = 16'h1111;
      cnt = 0;
      done_seen = 1'b0;
      for (int c = 0; c < CELLS + 50 && !done_seen; c++) begin
         #1;
         if (bus.cpu_ready_out) cnt++;
         @(negedge clk);
         done_seen = bus.done_out;
      end
      check("cont_done_seen", 32'(done_seen), 1);
      check("cont_cpu_stalled", 32'(cnt), 0);
      check("cont_ready_at_done", 32'(bus.cpu_ready_out), 1);
      @(negedge clk);
      bus.cpu_valid_in = 1'b0;
      check("cont_late_addr", 32'(bus.bram_addr_out), 10);
      check("cont_late_din", 32'(bus.bram_din_out), 32'h00001111);
      @(negedge clk);
      for (int i = 0; i < CELLS; i++) ref_mem[AW'(i)] = 16'h0720;
      ref_mem[10] = 16'h1111;
      check("cont_mem", 32'(mem_mismatches()), 0);

      // Reset in the middle of a scroll, then a no-op command.
      do_preload();
      @(negedge clk);
      bus.cmd_valid_in = 1'b1;
      bus.cmd_in       = 2'b10;
      bus.fill_in      = 16'h0000;
      @(negedge clk);
      bus.cmd_valid_in = 1'b0;
      done_seen = 1'b0;
      for (int c = 0; c < 2000 && !done_seen; c++) begin
         @(negedge clk);
         done_seen = bus.bram_we_out && (bus.bram_addr_out == 13'd100);
      end
      check("mid_reached_word100", 32'(done_seen), 1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_en", 32'(bus.bram_en_out), 0);
      check("mid_rst_we", 32'(bus.bram_we_out), 0);
      check("mid_rst_addr", 32'(bus.bram_addr_out), 0);
      check("mid_rst_din", 32'(bus.bram_din_out), 0);
      check("mid_rst_busy", 32'(bus.busy_out), 0);
      check("mid_rst_done", 32'(bus.done_out), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rel_cpu_ready", 32'(bus.cpu_ready_out), 1);
      check("mid_rel_cmd_ready", 32'(bus.cmd_ready_out), 1);
      cnt = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.done_out || bus.busy_out || bus.bram_en_out) cnt++;
      end
      check("mid_no_done", 32'(cnt), 0);
      bus.cmd_valid_in = 1'b1;
      bus.cmd_in       = 2'b11;
      #1 check("noop_cmd_ready", 32'(bus.cmd_ready_out), 1);
      @(negedge clk);
      bus.cmd_valid_in = 1'b0;
      check("noop_done", 32'(bus.done_out), 1);
      check("noop_en", 32'(bus.bram_en_out), 0);
      check("noop_busy", 32'(bus.busy_out), 0);
      @(negedge clk);
      check("noop_done_pulse", 32'(bus.done_out), 0);
      check("noop_en_after", 32'(bus.bram_en_out), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
